vga_sync_decoder: RTL and testbench
===================================

// Module: vga_sync_decoder
// PURPOSE
//  Receive-side counterpart of the VGA output stage. Samples hsync/vsync/RGB
//  on the pixel clock, locks onto the frame timing, and recovers pixel
//  coordinates plus a valid strobe for each visible pixel.
//  Feeds frame checkers and capture buffers in loopback benches and on-chip
//  self-test.
// PARAMETERS
//  COLOR_W   2    bits per colour channel
//  H_VISIBLE 640  visible pixels per line
//  H_FRONT   16   horizontal front porch, clocks
//  H_SYNC    96   hsync pulse width, clocks
//  H_BACK    48   horizontal back porch, clocks
//  V_VISIBLE 480  visible lines per frame
//  V_FRONT   10   vertical front porch, lines
//  V_SYNC    2    vsync pulse width, lines
//  V_BACK    33   vertical back porch, lines
//  SYNC_POL  0    0 = syncs active-low, 1 = active-high
// PORTS
//  clk         in   1        pixel clock; everything on posedge
//  rst_n       in   1        asynchronous active-low reset
//  hsync       in   1        horizontal sync, polarity per SYNC_POL
//  vsync       in   1        vertical sync, polarity per SYNC_POL
//  r, g, b     in   COLOR_W  pixel colour
//  pix_x       out  10       visible column, 0..H_VISIBLE-1
//  pix_y       out  10       visible row, 0..V_VISIBLE-1
//  pix_valid   out  1        pix_x/pix_y/colour outputs are a locked visible pixel
//  r_out, g_out, b_out  out  COLOR_W  colour aligned with pix_valid
//  frame_start out  1        1-cycle pulse with pixel (0,0)
//  locked      out  1        timing verified
//  sync_err    out  1        1-cycle pulse on any timing mismatch
// BEHAVIOUR
//  Reset, async on rst_n low:
//   - every output is 0; FSM is HUNT; counters are 0.
//   - Input sample regs load the deasserted sync level and colour 0.
//  Totals: H_TOTAL = sum of H_*; V_TOTAL = sum of V_*.
//   - HSTART = H_SYNC+H_BACK; VSTART = V_SYNC+V_BACK.
//  Stage 1: all inputs are registered (hs_q, vs_q, rgb_q); hs_d/vs_d hold the
//   previous hs_q/vs_q.
//   - hs_edge = hs_q asserted & hs_d deasserted; vs_edge is defined the same way.
//  hcnt (11b):
//   - 0 on hs_edge, else +1.
//   - Saturates at 2047; no wrap.
//  vcnt (11b):
//   - 0 on vs_edge, else +1 on hs_edge.
//   - vs_edge wins when both edges occur in the same cycle.
//   - Saturates at 2047.
//  Line check: at hs_edge, line_ok = (hcnt == H_TOTAL-1).
//  Frame check: at vs_edge, frame_ok = (vcnt == V_TOTAL-1).
//  FSM:
//   - HUNT:
//     - vs_edge -> CHECK.
//     - Checks are ignored, including on the entering edge.
//   - CHECK:
//     - hs_edge with !line_ok -> HUNT and sync_err.
//     - vs_edge with frame_ok -> LOCKED.
//     - vs_edge with !frame_ok -> HUNT and sync_err.
//   - LOCKED:
//     - Any failed line or frame check -> HUNT and sync_err.
//     - Otherwise stays in LOCKED.
//   - locked = (state == LOCKED), registered.
//   - A fault that drops lock clears pix_valid starting the cycle after sync_err.
//  Stage 2, output regs, updated every cycle:
//   - pix_valid = LOCKED & HSTART <= hcnt < HSTART+H_VISIBLE
//     & VSTART <= vcnt < VSTART+V_VISIBLE.
//   - pix_x = hcnt-HSTART; pix_y = vcnt-VSTART.
//   - rgb_out = rgb_q.
//   - When pix_valid would be 0, pix_x/pix_y/rgb_out are 0.
//   - frame_start = pix_valid & x==0 & y==0.
//  Latency: pin sample to pix_*/rgb_out is 2 clocks.
//  A sync asserted at reset release is seen as an edge; this is harmless
//   because the FSM is in HUNT.
//  Sync pulses longer or shorter than H_SYNC/V_SYNC are not checked; only
//   periods are checked.
// TESTING
//  1. rst_n=0 while driving a full frame -> all outputs stay 0 and locked=0.
//  2. Three clean 800x525 frames:
//     - locked=1 one clock after the 2nd vs_edge.
//     - Frame 3 has exactly 307200 pix_valid cycles and one frame_start.
//  3. Drive rgb=2 at pixel (5,7) with 1 elsewhere -> r_out=g_out=b_out=2
//     exactly when pix_x=5 and pix_y=7, 2 clocks after the sample edge.
//  4. While locked, one 799-clock line -> sync_err pulse at the next hs_edge;
//     locked=0 and pix_valid=0; relock after 2 further vs_edges.
//  5. Drop rst_n mid-line -> outputs 0 immediately with no clock;
//     after release, lock returns on the 2nd vs_edge.
//  6. SYNC_POL=1 with inverted syncs -> same results as scenario 2.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing recovery: samples sync and colour, verifies line and
// frame periods, and emits locked visible-pixel coordinates with aligned colour.
module vga_sync_decoder #(
  parameter int COLOR_W   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int SYNC_POL  = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hsync_i,
  input  logic               vsync_i,
  input  logic [COLOR_W-1:0] r_i,
  input  logic [COLOR_W-1:0] g_i,
  input  logic [COLOR_W-1:0] b_i,
  output logic [9:0]         pix_x_o,
  output logic [9:0]         pix_y_o,
  output logic               pix_valid_o,
  output logic [COLOR_W-1:0] r_out_o,
  output logic [COLOR_W-1:0] g_out_o,
  output logic [COLOR_W-1:0] b_out_o,
  output logic               frame_start_o,
  output logic               locked_o,
  output logic               sync_err_o
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HSTART  = H_SYNC + H_BACK;
  localparam int VSTART  = V_SYNC + V_BACK;
  localparam int RGB_W   = 3 * COLOR_W;

  localparam logic [10:0] CNT_MAX = 11'h7FF;
  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_LO    = 11'(HSTART);
  localparam logic [10:0] H_HI    = 11'(HSTART + H_VISIBLE);
  localparam logic [10:0] V_LO    = 11'(VSTART);
  localparam logic [10:0] V_HI    = 11'(VSTART + V_VISIBLE);

  localparam logic SYNC_ON  = (SYNC_POL != 0);
  localparam logic SYNC_OFF = (SYNC_POL == 0);

  localparam logic [1:0] S_HUNT   = 2'd0;
  localparam logic [1:0] S_CHECK  = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  // ---------------- stage 1: input sampling ----------------
  logic             hs_q, vs_q, hs_d, vs_d;
  logic [RGB_W-1:0] rgb_q, rgb_al_q;
  logic             hs_edge, vs_edge;

  // rgb_al_q lags rgb_q one clock so colour lines up with hcnt, which only
  // reaches 0 the clock after the sync edge is sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q     <= SYNC_OFF;
      vs_q     <= SYNC_OFF;
      hs_d     <= SYNC_OFF;
      vs_d     <= SYNC_OFF;
      rgb_q    <= '0;
      rgb_al_q <= '0;
    end else begin
      hs_q     <= hsync_i;
      vs_q     <= vsync_i;
      hs_d     <= hs_q;
      vs_d     <= vs_q;
      rgb_q    <= {r_i, g_i, b_i};
      rgb_al_q <= rgb_q;
    end
  end

  assign hs_edge = (hs_q == SYNC_ON) && (hs_d == SYNC_OFF);
  assign vs_edge = (vs_q == SYNC_ON) && (vs_d == SYNC_OFF);

  // ---------------- position counters ----------------
  logic [10:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;

  always_comb begin
    hcnt_d = hcnt_q;
    if (hs_edge)                hcnt_d = '0;
    else if (hcnt_q != CNT_MAX) hcnt_d = hcnt_q + 11'd1;

    vcnt_d = vcnt_q;
    if (vs_edge)                           vcnt_d = '0;
    else if (hs_edge && vcnt_q != CNT_MAX) vcnt_d = vcnt_q + 11'd1;
  end

  // ---------------- lock FSM ----------------
  logic [1:0] state_q, state_d;
  logic       err_d, check_fail;
  logic       sync_err_q, locked_q;

  assign check_fail = (hs_edge && (hcnt_q != H_LAST)) ||
                      (vs_edge && (vcnt_q != V_LAST));

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    case (state_q)
      S_HUNT: begin
        if (vs_edge) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (check_fail) begin
          state_d = S_HUNT;
          err_d   = 1'b1;
        end else if (vs_edge) begin
          state_d = S_LOCKED;
        end
      end
      S_LOCKED: begin
        if (check_fail) begin
          state_d = S_HUNT;
          err_d   = 1'b1;
        end
      end
      default: state_d = S_HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      state_q    <= S_HUNT;
      sync_err_q <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      state_q    <= state_d;
      sync_err_q <= err_d;
      locked_q   <= (state_d == S_LOCKED);
    end
  end

  // ---------------- stage 2: output registers ----------------
  logic             vis;
  logic [9:0]       pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [RGB_W-1:0] rgb_out_q, rgb_out_d;
  logic             pix_valid_q, frame_start_q, frame_start_d;

  assign vis = (state_q == S_LOCKED) &&
               (hcnt_q >= H_LO) && (hcnt_q < H_HI) &&
               (vcnt_q >= V_LO) && (vcnt_q < V_HI);

  always_comb begin
    pix_x_d   = '0;
    pix_y_d   = '0;
    rgb_out_d = '0;
    if (vis) begin
      pix_x_d   = 10'(hcnt_q - H_LO);
      pix_y_d   = 10'(vcnt_q - V_LO);
      rgb_out_d = rgb_al_q;
    end
    frame_start_d = vis && (hcnt_q == H_LO) && (vcnt_q == V_LO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_valid_q   <= 1'b0;
      rgb_out_q     <= '0;
      frame_start_q <= 1'b0;
    end else begin
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_valid_q   <= vis;
      rgb_out_q     <= rgb_out_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pix_x_o       = pix_x_q;
  assign pix_y_o       = pix_y_q;
  assign pix_valid_o   = pix_valid_q;
  assign r_out_o       = rgb_out_q[RGB_W-1 -: COLOR_W];
  assign g_out_o       = rgb_out_q[COLOR_W +: COLOR_W];
  assign b_out_o       = rgb_out_q[0 +: COLOR_W];
  assign frame_start_o = frame_start_q;
  assign locked_o      = locked_q;
  assign sync_err_o    = sync_err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a shrunken 15x15 raster; an active-low
// and an active-high instance share one generator and are checked in parallel.
module tb_vga_sync_decoder;
  localparam int CW  = 2;
  localparam int HV  = 8, HF = 2, HSY = 3, HB = 2;
  localparam int VV  = 10, VF = 1, VSY = 2, VB = 2;
  localparam int HT  = HV + HF + HSY + HB;  // 15
  localparam int VT  = VV + VF + VSY + VB;  // 15
  localparam int HS  = HSY + HB;            // 5
  localparam int VS  = VSY + VB;            // 4

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          hs_pin = 1'b1, vs_pin = 1'b1;  // active-low convention
  logic [CW-1:0] col = '0;

  logic [9:0]    px [2], py [2];
  logic          pv [2], fs [2], lk [2], se [2];
  logic [CW-1:0] ro [2], go [2], bo [2];

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  vga_sync_decoder #(
    .COLOR_W(CW), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB), .SYNC_POL(0)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .hsync_i(hs_pin), .vsync_i(vs_pin),
    .r_i(col), .g_i(col), .b_i(col),
    .pix_x_o(px[0]), .pix_y_o(py[0]), .pix_valid_o(pv[0]),
    .r_out_o(ro[0]), .g_out_o(go[0]), .b_out_o(bo[0]),
    .frame_start_o(fs[0]), .locked_o(lk[0]), .sync_err_o(se[0])
  );

  vga_sync_decoder #(
    .COLOR_W(CW), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB), .SYNC_POL(1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .hsync_i(~hs_pin), .vsync_i(~vs_pin),
    .r_i(col), .g_i(col), .b_i(col),
    .pix_x_o(px[1]), .pix_y_o(py[1]), .pix_valid_o(pv[1]),
    .r_out_o(ro[1]), .g_out_o(go[1]), .b_out_o(bo[1]),
    .frame_start_o(fs[1]), .locked_o(lk[1]), .sync_err_o(se[1])
  );

  // generator position and the pixel it drove on the current step
  int gx = 0, gy = 0, fno = 0, short_f = -1, short_y = -1;
  int cx, cy, cf;
  int h0x = -100, h0y = -100, h1x = -100, h1y = -100;

  bit mon_en = 1'b0, rst_mon = 1'b0;
  int nz [2], nval [2], nfs [2], perr [2], n2 [2], ok2 [2], pos2 [2];
  int nerr [2], errpos [2], rise [2], aft_pv [2], aft_lk [2];
  logic lk_prev [2], se_prev [2];

  function automatic int enc(input int f, input int x, input int y);
    return f * 10000 + y * 100 + x;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    int ex, ey, len;
    bit evis;
    logic [CW-1:0] ecol;
    hs_pin = (gx < HSY) ? 1'b0 : 1'b1;
    vs_pin = (gy < VSY) ? 1'b0 : 1'b1;
    col    = (gx == HS + 5 && gy == VS + 7) ? 2'd2 : 2'd1;
    cx = gx; cy = gy; cf = fno;
    @(posedge clk);
    #1;
    // outputs now reflect the pins driven two edges ago
    ex = h1x; ey = h1y;
    h1x = h0x; h1y = h0y; h0x = cx; h0y = cy;
    evis = (ex >= HS) && (ex < HS + HV) && (ey >= VS) && (ey < VS + VV);
    ecol = !evis ? 2'd0 : (ex == HS + 5 && ey == VS + 7) ? 2'd2 : 2'd1;
    for (int d = 0; d < 2; d++) begin
      if (rst_mon && ((|{px[d], py[d], pv[d], ro[d], go[d], bo[d], fs[d], lk[d], se[d]}) !== 1'b0))
        nz[d]++;
      if (mon_en) begin
        if (pv[d] !== evis ||
            px[d] !== (evis ? 10'(ex - HS) : 10'd0) ||
            py[d] !== (evis ? 10'(ey - VS) : 10'd0) ||
            ro[d] !== ecol || go[d] !== ecol || bo[d] !== ecol ||
            fs[d] !== (evis && ex == HS && ey == VS))
          perr[d]++;
        if (pv[d] === 1'b1) nval[d]++;
        if (fs[d] === 1'b1) nfs[d]++;
        if (ro[d] === 2'd2) begin
          n2[d]++;
          pos2[d] = enc(cf, cx, cy);
          if (pv[d] === 1'b1 && px[d] == 10'd5 && py[d] == 10'd7 && go[d] == 2'd2 && bo[d] == 2'd2)
            ok2[d]++;
        end
      end
      if (se[d] === 1'b1) begin
        nerr[d]++;
        errpos[d] = enc(cf, cx, cy);
      end
      if (se_prev[d] === 1'b1) begin
        aft_pv[d] = int'(pv[d]);
        aft_lk[d] = int'(lk[d]);
      end
      if (lk[d] === 1'b1 && lk_prev[d] !== 1'b1) rise[d] = enc(cf, cx, cy);
      lk_prev[d] = lk[d];
      se_prev[d] = se[d];
    end
    gx++;
    len = (fno == short_f && gy == short_y) ? HT - 1 : HT;
    if (gx >= len) begin
      gx = 0;
      gy++;
      if (gy == VT) begin
        gy = 0;
        fno++;
      end
    end
  endtask

  task automatic run_frames(input int n);
    int target;
    target = fno + n;
    while (fno != target) step();
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      nz[d] = 0; nval[d] = 0; nfs[d] = 0; perr[d] = 0; n2[d] = 0; ok2[d] = 0;
      pos2[d] = -1; nerr[d] = 0; errpos[d] = -1; rise[d] = -1;
      aft_pv[d] = -1; aft_lk[d] = -1; lk_prev[d] = 1'b0; se_prev[d] = 1'b0;
    end

    // held in reset for a whole frame of live input
    rst_mon = 1'b1;
    run_frames(1);
    rst_mon = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_quiet[%0d]", d), nz[d], 0);
      chk($sformatf("reset_locked[%0d]", d), int'(lk[d]), 0);
    end

    // three clean frames; lock one clock after the 2nd vs edge (frame 2 start)
    rst_n = 1'b1;
    run_frames(2);
    mon_en = 1'b1;
    run_frames(1);
    mon_en = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("lock_rise[%0d]", d), rise[d], enc(2, 1, 0));
      chk($sformatf("valid_count[%0d]", d), nval[d], HV * VV);
      chk($sformatf("frame_start_count[%0d]", d), nfs[d], 1);
      chk($sformatf("pixel_model_err[%0d]", d), perr[d], 0);
      chk($sformatf("colour2_count[%0d]", d), n2[d], 1);
      chk($sformatf("colour2_at_5_7[%0d]", d), ok2[d], 1);
      chk($sformatf("colour2_latency[%0d]", d), pos2[d], enc(3, HS + 5 + 2, VS + 7));
      chk($sformatf("clean_no_err[%0d]", d), nerr[d], 0);
    end

    // one short line in frame 4, then relock over frames 5 and 6
    for (int d = 0; d < 2; d++) rise[d] = -1;
    short_f = 4;
    short_y = 8;
    run_frames(3);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("short_line_err_pos[%0d]", d), errpos[d], enc(4, 1, 9));
      chk($sformatf("after_err_valid[%0d]", d), aft_pv[d], 0);
      chk($sformatf("after_err_locked[%0d]", d), aft_lk[d], 0);
      chk($sformatf("relock_rise[%0d]", d), rise[d], enc(6, 1, 0));
      chk($sformatf("short_line_err_count[%0d]", d), nerr[d], 1);
    end

    // async reset in the middle of a visible line of frame 7
    for (int i = 0; i < (VS + 2) * HT + HS + 4; i++) step();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("pre_reset_valid[%0d]", d), int'(pv[d]), 1);
      chk($sformatf("pre_reset_x[%0d]", d), int'(px[d]), 1);
      chk($sformatf("pre_reset_y[%0d]", d), int'(py[d]), 2);
    end
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("async_reset_outputs[%0d]", d),
          int'({px[d], py[d], pv[d], ro[d], go[d], bo[d], fs[d], lk[d], se[d]} != '0), 0);
      nz[d] = 0;
      rise[d] = -1;
    end
    rst_mon = 1'b1;
    for (int i = 0; i < 10; i++) step();
    rst_mon = 1'b0;
    rst_n = 1'b1;
    while (fno != 10) step();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_hold_quiet[%0d]", d), nz[d], 0);
      chk($sformatf("post_reset_rise[%0d]", d), rise[d], enc(9, 1, 0));
      chk($sformatf("post_reset_err_count[%0d]", d), nerr[d], 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
